// File: rtl/rf_wb_arb_if.sv
// Bus bundle between the writeback stage, the secondary writeback source and
// the register-file write port owned by rf_wb_arb.
interface rf_wb_arb_if;
    logic        a_valid;
    logic [2:0]  a_sel;
    logic [15:0] a_data;
    logic        stall_a;

    logic        b_valid;
    logic        b_ready;
    logic [2:0]  b_sel;
    logic [15:0] b_data;

    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic [7:0]  pend;
    logic        err;

    // The sources and the register file together form the master side.
    modport master (
        output a_valid, a_sel, a_data, b_valid, b_sel, b_data,
        input  stall_a, b_ready, wr_en, wr_sel, wr_data, pend, err
    );

    modport slave (
        input  a_valid, a_sel, a_data, b_valid, b_sel, b_data,
        output stall_a, b_ready, wr_en, wr_sel, wr_data, pend, err
    );
endinterface

// File: rtl/rf_wb_arb.sv
// Writeback arbiter: pipeline source A has priority over the 2-entry FIFO of
// source B, with a starvation stall that lets B through every STARVE_LIMIT A wins.
module rf_wb_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    rf_wb_arb_if.slave wb
);

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
    } entry_t;

    entry_t      fifo_q [2];
    logic        head_q, tail_q;
    logic [1:0]  count_q, count_d;
    logic [3:0]  starve_q, starve_d;
    logic        stall_q, stall_d;
    logic        wr_en_q;
    logic [2:0]  wr_sel_q;
    logic [15:0] wr_data_q;
    logic        err_q;

    logic        grant_a, grant_b, push;
    logic [7:0]  pend;

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        grant_a  = wb.a_valid && !stall_q;
        grant_b  = !grant_a && (count_q != 2'd0);
        push     = wb.b_valid && (count_q != 2'd2);
        count_d  = count_q + 2'(push) - 2'(grant_b);
        starve_d = (grant_a && (count_q != 2'd0)) ? starve_q + 4'd1 : 4'd0;
        stall_d  = (starve_d == 4'(STARVE_LIMIT));
    end

    // An entry is live when it lies within count_q slots from the head.
    always_comb begin
        pend = 8'h00;
        for (int i = 0; i < 2; i++) begin
            if (count_q == 2'd2 || (count_q == 2'd1 && head_q == 1'(i)))
                pend[fifo_q[i].sel] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            starve_q  <= 4'd0;
            stall_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 3'd0;
            wr_data_q <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            wr_en_q  <= grant_a || grant_b;
            if (push)
                tail_q <= tail_q + 1'b1;
            if (grant_a) begin
                wr_sel_q  <= wb.a_sel;
                wr_data_q <= wb.a_data;
                if (pend[wb.a_sel])
                    err_q <= 1'b1;
            end else if (grant_b) begin
                wr_sel_q  <= fifo_q[head_q].sel;
                wr_data_q <= fifo_q[head_q].data;
                head_q    <= head_q + 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which slots hold valid data.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[tail_q] <= '{sel: wb.b_sel, data: wb.b_data};
    end

    assign wb.stall_a = stall_q;
    assign wb.b_ready = (count_q != 2'd2);
    assign wb.wr_en   = wr_en_q;
    assign wb.wr_sel  = wr_sel_q;
    assign wb.wr_data = wr_data_q;
    assign wb.pend    = pend;
    assign wb.err     = err_q;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Self-checking bench for rf_wb_arb: directed scenarios plus a randomized run
// compared against a queue-based behavioural model of the arbiter.
module tb_rf_wb_arb;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rf_wb_arb_if wb ();

    rf_wb_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    ent_t        mq[$];
    int          m_starve;
    bit          m_stall;
    bit          m_wr_en;
    logic [2:0]  m_wr_sel;
    logic [15:0] m_wr_data;
    bit          m_err;
    bit          m_pushed;

    function automatic logic [7:0] model_pend();
        logic [7:0] p = 8'h00;
        foreach (mq[i]) p[mq[i].sel] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_starve  = 0;
        m_stall   = 0;
        m_wr_en   = 0;
        m_wr_sel  = 3'd0;
        m_wr_data = 16'h0000;
        m_err     = 0;
        m_pushed  = 0;
    endtask

    // Applies the arbitration rules for one posedge using the inputs held across it.
    task automatic model_edge();
        int         n      = mq.size();
        bit         can_in = (n < 2);
        logic [7:0] p      = model_pend();
        bit         ga     = wb.a_valid && !m_stall;
        ent_t       head;
        if (ga) begin
            if (p[wb.a_sel]) m_err = 1;
            m_wr_en   = 1;
            m_wr_sel  = wb.a_sel;
            m_wr_data = wb.a_data;
        end else if (n != 0) begin
            head      = mq.pop_front();
            m_wr_en   = 1;
            m_wr_sel  = head.sel;
            m_wr_data = head.data;
        end else begin
            m_wr_en = 0;
        end
        m_starve = (ga && n != 0) ? m_starve + 1 : 0;
        m_stall  = (m_starve == LIMIT);
        m_pushed = wb.b_valid && can_in;
        if (m_pushed) mq.push_back('{sel: wb.b_sel, data: wb.b_data});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_a(input bit v, input logic [2:0] s, input logic [15:0] d);
        wb.a_valid = v;
        wb.a_sel   = s;
        wb.a_data  = d;
    endtask

    task automatic drive_b(input bit v, input logic [2:0] s, input logic [15:0] d);
        wb.b_valid = v;
        wb.b_sel   = s;
        wb.b_data  = d;
    endtask

    task automatic test_reset();
        drive_a(0, 3'd0, 16'h0);
        drive_b(0, 3'd0, 16'h0);
        model_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({wb.wr_en, wb.wr_sel, wb.wr_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_wr: got en=%0b sel=%0d data=%h, want 0/0/0000", wb.wr_en, wb.wr_sel, wb.wr_data);
        end
        checks++;
        if ({wb.stall_a, wb.b_ready, wb.pend, wb.err} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags: got stall=%0b ready=%0b pend=%h err=%0b, want 0/1/00/0", wb.stall_a, wb.b_ready, wb.pend, wb.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_a_only();
        @(negedge clk);
        drive_a(1, 3'd3, 16'h1234);
        tick();
        checks++;
        if ({wb.wr_en, wb.wr_sel, wb.wr_data} !== {1'b1, 3'd3, 16'h1234}) begin
            errors++;
            $display("FAIL a_only_write: got en=%0b sel=%0d data=%h, want 1/3/1234", wb.wr_en, wb.wr_sel, wb.wr_data);
        end
        @(negedge clk);
        drive_a(0, 3'd0, 16'h0);
        tick();
        checks++;
        if (wb.wr_en !== 1'b0 || wb.wr_sel !== 3'd3) begin
            errors++;
            $display("FAIL a_only_idle: got en=%0b sel=%0d, want 0/3", wb.wr_en, wb.wr_sel);
        end
    endtask

    task automatic test_b_only();
        @(negedge clk);
        drive_b(1, 3'd5, 16'hBEEF);
        tick();
        checks++;
        if (wb.pend !== 8'h20 || wb.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL b_only_queued: got pend=%h en=%0b, want 20/0", wb.pend, wb.wr_en);
        end
        @(negedge clk);
        drive_b(0, 3'd0, 16'h0);
        tick();
        checks++;
        if ({wb.wr_en, wb.wr_sel, wb.wr_data, wb.pend} !== {1'b1, 3'd5, 16'hBEEF, 8'h00}) begin
            errors++;
            $display("FAIL b_only_write: got en=%0b sel=%0d data=%h pend=%h, want 1/5/beef/00", wb.wr_en, wb.wr_sel, wb.wr_data, wb.pend);
        end
        tick();
        checks++;
        if (wb.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL b_only_done: got en=%0b, want 0", wb.wr_en);
        end
    endtask

    task automatic test_starvation();
        @(negedge clk);
        drive_a(1, 3'd0, 16'hA000);
        drive_b(1, 3'd7, 16'h7777);
        tick();
        @(negedge clk);
        drive_b(0, 3'd0, 16'h0);
        for (int i = 1; i <= LIMIT; i++) begin
            tick();
            checks++;
            if ({wb.wr_en, wb.wr_sel, wb.wr_data} !== {1'b1, 3'd0, 16'hA000} || wb.stall_a !== (i == LIMIT)) begin
                errors++;
                $display("FAIL starve_a%0d: got en=%0b sel=%0d data=%h stall=%0b, want 1/0/a000/%0b",
                         i, wb.wr_en, wb.wr_sel, wb.wr_data, wb.stall_a, (i == LIMIT));
            end
        end
        tick();
        checks++;
        if ({wb.wr_en, wb.wr_sel, wb.wr_data, wb.stall_a, wb.pend} !== {1'b1, 3'd7, 16'h7777, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL starve_b: got en=%0b sel=%0d data=%h stall=%0b pend=%h, want 1/7/7777/0/00",
                     wb.wr_en, wb.wr_sel, wb.wr_data, wb.stall_a, wb.pend);
        end
        tick();
        checks++;
        if (wb.wr_sel !== 3'd0 || wb.wr_data !== 16'hA000 || wb.stall_a !== 1'b0) begin
            errors++;
            $display("FAIL starve_resume: got sel=%0d data=%h stall=%0b, want 0/a000/0", wb.wr_sel, wb.wr_data, wb.stall_a);
        end
        @(negedge clk);
        drive_a(0, 3'd0, 16'h0);
        tick();
    endtask

    task automatic test_full();
        logic [2:0] seen[$];
        bit         third_pending = 1;
        @(negedge clk);
        drive_a(1, 3'd0, 16'hA0A0);
        drive_b(1, 3'd1, 16'h0001);
        tick();
        @(negedge clk);
        drive_b(1, 3'd6, 16'h0006);
        tick();
        checks++;
        if (wb.b_ready !== 1'b0 || wb.pend !== 8'h42) begin
            errors++;
            $display("FAIL full_state: got ready=%0b pend=%h, want 0/42", wb.b_ready, wb.pend);
        end
        @(negedge clk);
        drive_b(1, 3'd3, 16'h0003);
        for (int c = 0; c < 30; c++) begin
            tick();
            if (m_pushed) third_pending = 0;
            if (wb.wr_en && wb.wr_sel != 3'd0) seen.push_back(wb.wr_sel);
            checks++;
            if ({wb.wr_en, wb.wr_sel, wb.wr_data, wb.stall_a, wb.b_ready} !==
                {m_wr_en, m_wr_sel, m_wr_data, m_stall, 1'(mq.size() < 2)}) begin
                errors++;
                $display("FAIL full_cycle%0d: got en=%0b sel=%0d data=%h stall=%0b ready=%0b, want %0b/%0d/%h/%0b/%0b",
                         c, wb.wr_en, wb.wr_sel, wb.wr_data, wb.stall_a, wb.b_ready,
                         m_wr_en, m_wr_sel, m_wr_data, m_stall, (mq.size() < 2));
            end
            @(negedge clk);
            if (!third_pending) drive_b(0, 3'd0, 16'h0);
        end
        drive_a(0, 3'd0, 16'h0);
        tick();
        tick();
        checks++;
        if (seen.size() != 3 || seen[0] !== 3'd1 || seen[1] !== 3'd6 || seen[2] !== 3'd3) begin
            errors++;
            $display("FAIL full_order: got %0d B writes %p, want 3 writes r1,r6,r3", seen.size(), seen);
        end
        checks++;
        if (wb.b_ready !== 1'b1 || wb.pend !== 8'h00) begin
            errors++;
            $display("FAIL full_drained: got ready=%0b pend=%h, want 1/00", wb.b_ready, wb.pend);
        end
    endtask

    task automatic test_waw();
        @(negedge clk);
        drive_b(1, 3'd2, 16'h2BBB);
        tick();
        @(negedge clk);
        drive_b(0, 3'd0, 16'h0);
        drive_a(1, 3'd2, 16'h2AAA);
        tick();
        checks++;
        if (wb.err !== 1'b1 || wb.wr_sel !== 3'd2 || wb.wr_data !== 16'h2AAA) begin
            errors++;
            $display("FAIL waw_set: got err=%0b sel=%0d data=%h, want 1/2/2aaa", wb.err, wb.wr_sel, wb.wr_data);
        end
        @(negedge clk);
        drive_a(0, 3'd0, 16'h0);
        tick();
        tick();
        checks++;
        if (wb.err !== 1'b1 || wb.pend !== 8'h00) begin
            errors++;
            $display("FAIL waw_sticky: got err=%0b pend=%h, want 1/00", wb.err, wb.pend);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        drive_a(1, 3'd5, 16'h5555);
        drive_b(1, 3'd1, 16'h1111);
        tick();
        @(negedge clk);
        drive_b(1, 3'd4, 16'h2222);
        tick();
        checks++;
        if (wb.b_ready !== 1'b0 || wb.pend !== 8'h12) begin
            errors++;
            $display("FAIL midreset_full: got ready=%0b pend=%h, want 0/12", wb.b_ready, wb.pend);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({wb.wr_en, wb.pend, wb.b_ready, wb.stall_a, wb.err} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_async: got en=%0b pend=%h ready=%0b stall=%0b err=%0b, want 0/00/1/0/0",
                     wb.wr_en, wb.pend, wb.b_ready, wb.stall_a, wb.err);
        end
        drive_a(0, 3'd0, 16'h0);
        drive_b(0, 3'd0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (wb.wr_en !== 1'b0 || wb.pend !== 8'h00) begin
                errors++;
                $display("FAIL midreset_after%0d: got en=%0b pend=%h, want 0/00", c, wb.wr_en, wb.pend);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!m_stall)
                drive_a(($urandom_range(0, 9) < 7), 3'($urandom), 16'($urandom));
            drive_b(($urandom_range(0, 1) == 1), 3'($urandom), 16'($urandom));
            tick();
            checks++;
            if ({wb.wr_en, wb.wr_sel, wb.wr_data, wb.stall_a, wb.b_ready, wb.pend, wb.err} !==
                {m_wr_en, m_wr_sel, m_wr_data, m_stall, 1'(mq.size() < 2), model_pend(), m_err}) begin
                errors++;
                $display("FAIL random%0d: got en=%0b sel=%0d data=%h stall=%0b ready=%0b pend=%h err=%0b, want %0b/%0d/%h/%0b/%0b/%h/%0b",
                         c, wb.wr_en, wb.wr_sel, wb.wr_data, wb.stall_a, wb.b_ready, wb.pend, wb.err,
                         m_wr_en, m_wr_sel, m_wr_data, m_stall, (mq.size() < 2), model_pend(), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_b_only();
        test_starvation();
        test_full();
        test_waw();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
